// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, accumulator type and the ReLU helper for the systolic datapath.
package systolic_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 32;

    typedef logic signed [DEFAULT_ACC_WIDTH-1:0] acc_t;

    function automatic acc_t relu(input acc_t v);
        return v[$bits(acc_t)-1] ? '0 : v;
    endfunction
endpackage

// File: rtl/output_deskew_collector_if.sv
// output_deskew_collector_if: row-injection credit and aligned-row valid/ready bus of the collector.
interface output_deskew_collector_if #(
    parameter int N = 2,
    parameter int W = 32
);
    logic in_valid, in_ready, out_valid, out_ready;
    logic signed [W-1:0] c_in [N];
    logic signed [W-1:0] out_data [N];

    modport master (output in_valid, c_in, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, c_in, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sync_row_fifo.sv
// sync_row_fifo: row FIFO with a registered first-word-fall-through head and sticky overflow flag.
module sync_row_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_pop, do_push;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && full && !do_pop) overflow <= 1'b1;
            // head register tracks the oldest entry; bypass when the new row becomes the head
            if (do_push && (empty || (do_pop && count == (AW+1)'(1)))) rd_data <= wr_data;
            else if (do_pop && count > (AW+1)'(1)) rd_data <= mem[rptr + 1'b1];
        end

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wr_data;
endmodule

// File: rtl/output_deskew_collector.sv
// output_deskew_collector: re-aligns column-skewed bottom-row sums into rows, buffers them and
// issues credit to upstream; define OUTPUT_RELU_EN to clamp negative results to zero.
module output_deskew_collector
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE   = 2,
    parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
    parameter int PIPE_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output_deskew_collector_if.slave bus,
    output logic overflow
);
    localparam int L  = PIPE_LATENCY + ARRAY_SIZE - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = ARRAY_SIZE * ACC_WIDTH;

    logic [L-1:0] vpipe;
    logic signed [ACC_WIDTH-1:0] aligned [ARRAY_SIZE];
    logic signed [ACC_WIDTH-1:0] wdata [ARRAY_SIZE];
    logic [RW-1:0] wr_flat, rd_flat;
    logic [AW:0] count;
    logic full, empty;

    always_ff @(posedge clk or posedge rst)
        if (rst) vpipe <= '0;
        else if (enable) vpipe <= {vpipe[L-2:0], bus.in_valid};

    // column j lags column 0 by j cycles, so it waits N-1-j cycles to line up with the last column
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        localparam int D = ARRAY_SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j] = bus.c_in[j];
        end else begin : g_dly
            logic signed [ACC_WIDTH-1:0] sr [D];
            always_ff @(posedge clk or posedge rst)
                if (rst) sr <= '{default: '0};
                else if (enable) begin
                    sr[0] <= bus.c_in[j];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            assign aligned[j] = sr[D-1];
        end
`ifdef OUTPUT_RELU_EN
        if (ACC_WIDTH == $bits(acc_t)) begin : g_relu
            assign wdata[j] = relu(aligned[j]);
        end else begin : g_clamp
            assign wdata[j] = aligned[j][ACC_WIDTH-1] ? '0 : aligned[j];
        end
`else
        assign wdata[j] = aligned[j];
`endif
        assign wr_flat[j*ACC_WIDTH +: ACC_WIDTH] = wdata[j];
        assign bus.out_data[j] = rd_flat[j*ACC_WIDTH +: ACC_WIDTH];
    end

    // rows still in the array hold a reserved slot, so credit counts them with the buffered ones
    assign bus.in_ready  = !full && (int'(count) + $countones(vpipe) < FIFO_DEPTH);
    assign bus.out_valid = !empty;

    sync_row_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (enable && vpipe[L-1]),
        .pop      (bus.out_ready),
        .wr_data  (wr_flat),
        .rd_data  (rd_flat),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );
endmodule

// File: tb/tb_output_deskew_collector.sv
// tb_output_deskew_collector: directed and random rows checked against a queue-based row model.
module tb_output_deskew_collector;
    localparam int N = 2, W = 32, P = 2, D = 4, L = P + N - 1, H = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic overflow;

    output_deskew_collector_if #(.N(N), .W(W)) bus ();

    output_deskew_collector #(
        .ARRAY_SIZE(N), .ACC_WIDTH(W), .PIPE_LATENCY(P), .FIFO_DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ec = 0;
    bit inj_v [H];
    logic signed [W-1:0] inj_d [H][N];
    logic [2*W-1:0] q [$];
    logic [2*W-1:0] last_head = '0;
    bit ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic signed [W-1:0] mr(input logic signed [W-1:0] v);
`ifdef OUTPUT_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int inflight();
        int s = 0;
        for (int k = 1; k <= L; k++) if (ec - k >= 0 && inj_v[ec-k]) s++;
        return s;
    endfunction

    function automatic bit mrdy();
        return q.size() + inflight() < D;
    endfunction

    task automatic model_reset();
        q.delete();
        ovf = 1'b0;
        last_head = '0;
        for (int i = 0; i < H; i++) inj_v[i] = 1'b0;
    endtask

    // one clock cycle: drive inputs, check outputs mid-cycle, then advance the model
    task automatic step(input bit en, input bit iv, input bit ordy,
                        input logic signed [W-1:0] d0, input logic signed [W-1:0] d1);
        int idx, w;
        bit pop, wr;
        enable = en;
        bus.in_valid = iv;
        bus.out_ready = ordy;
        for (int j = 0; j < N; j++) begin
            idx = ec - P - j;
            bus.c_in[j] = (idx >= 0 && inj_v[idx]) ? inj_d[idx][j] : W'($urandom);
        end
        #3;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("out_data", {bus.out_data[0], bus.out_data[1]}, q.size() != 0 ? q[0] : last_head);
        chk("in_ready", 64'(bus.in_ready), 64'(mrdy()));
        chk("overflow", 64'(overflow), 64'(ovf));
        pop = q.size() != 0 && ordy;
        w = ec - L;
        wr = en && w >= 0 && inj_v[w];
        if (pop) last_head = q.pop_front();
        if (wr) begin
            if (q.size() == D) ovf = 1'b1;
            else q.push_back({mr(inj_d[w][0]), mr(inj_d[w][1])});
        end
        if (en) begin
            inj_v[ec] = iv;
            inj_d[ec][0] = d0;
            inj_d[ec][1] = d1;
            ec++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < N; j++) bus.c_in[j] = '0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", {bus.out_data[0], bus.out_data[1]}, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single row {5,-7}
        step(1, 1, 1, 5, -7);
        repeat (6) step(1, 0, 1, W'($urandom), W'($urandom));

        // same row with enable low for two cycles
        step(1, 1, 1, 5, -7);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (6) step(1, 0, 1, W'($urandom), W'($urandom));

        // backpressure: inject only while credit is available
        repeat (8) step(1, mrdy(), 0, W'($urandom), W'($urandom));
        repeat (4) step(1, 0, 0, W'($urandom), W'($urandom));

        // full FIFO with simultaneous push and pop
        repeat (L) step(1, 1, 0, W'($urandom), W'($urandom));
        repeat (8) step(1, 1, 1, W'($urandom), W'($urandom));
        repeat (12) step(1, 0, 1, W'($urandom), W'($urandom));

        // overflow: forced row into a full FIFO with no pop
        repeat (4) step(1, mrdy(), 0, W'($urandom), W'($urandom));
        repeat (4) step(1, 0, 0, W'($urandom), W'($urandom));
        step(1, 1, 0, W'($urandom), W'($urandom));
        repeat (6) step(1, 0, 0, W'($urandom), W'($urandom));
        repeat (8) step(1, 0, 1, W'($urandom), W'($urandom));

        // reset with rows buffered and in flight
        repeat (2) step(1, 1, 0, W'($urandom), W'($urandom));
        repeat (4) step(1, 0, 0, W'($urandom), W'($urandom));
        repeat (2) step(1, 1, 0, W'($urandom), W'($urandom));
        enable = 1'b1;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_out_data", {bus.out_data[0], bus.out_data[1]}, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) step(1, 0, 1, W'($urandom), W'($urandom));

        // random traffic with occasional credit violations
        repeat (600)
            step($urandom_range(0, 3) != 0,
                 mrdy() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 2) != 0, W'($urandom), W'($urandom));
        repeat (20) step(1, 0, 1, W'($urandom), W'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/output_deskew_collector.md
Name: output_deskew_collector

Overview:
- Sits directly downstream of the N×N weight-stationary systolic array.
- Consumes the bottom-row partial sums `c_out[N]`. These emerge column-skewed: column j is valid j cycles after column 0.
- Re-aligns them into one row vector per input row, buffers rows in a FIFO, and presents them on a valid/ready interface.
- Issues a credit-based `in_ready` so upstream never injects more rows than the FIFO can absorb.

Parameters:
- ARRAY_SIZE, 2: array dimension N (columns collected).
- ACC_WIDTH, 32: width of each signed accumulator value.
- PIPE_LATENCY, 2: enabled cycles from `in_valid` at the array input to column-0 `c_out` being valid.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  array advance enable; same signal driven to the array.
- in_valid  input  1  asserted in the cycle a row `a_in` is presented to the array.
- in_ready  output  1  upstream may assert `in_valid` this cycle.
- c_in  input  ARRAY_SIZE×ACC_WIDTH signed (unpacked [ARRAY_SIZE])  array bottom-row `c_out`.
- out_valid  output  1  `out_data` holds an aligned row.
- out_ready  input  1  consumer accepts the row.
- out_data  output  ARRAY_SIZE×ACC_WIDTH signed (unpacked [ARRAY_SIZE])  aligned result row.
- overflow  output  1  sticky: a write was attempted into a full FIFO with no pop.

Behaviour:
- Reset (async, active-high, immediate):
  - valid shift register, deskew registers and FIFO pointers/count are cleared.
  - `out_valid`=0, `out_data`=0, `overflow`=0, `in_ready`=1.
  - A mid-operation reset discards all in-flight and buffered rows; there is no partial-row output afterwards.
- Token tracking:
  - Shift register `vpipe` of length L = PIPE_LATENCY + ARRAY_SIZE − 1.
  - Advances only when `enable`=1; bit 0 loads `in_valid`.
  - When `enable`=0, all pipeline state (vpipe, deskew) holds.
- Deskew:
  - Column j passes through (ARRAY_SIZE−1−j) registers, also gated by `enable`. Column N−1 is combinational.
  - All columns of the row injected at enabled cycle t are aligned at enabled cycle t+L.
- FIFO write:
  - Occurs when the token exits `vpipe` (bit L−1 set) and `enable`=1; the aligned vector is written.
  - FIFO read/pop is independent of `enable`.
  - Latency: `out_valid` rises one clk after the write into an empty FIFO. Minimum latency from `in_valid` is L+1 cycles with `enable` held high.
- Handshake:
  - Pop on `out_valid` && `out_ready`.
  - `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_data` is the FIFO head, registered (first-word-fall-through from a registered memory read).
- Credit:
  - `in_ready` = (fifo_count + popcount(vpipe)) < FIFO_DEPTH, computed combinationally from registered state.
  - A pop in the current cycle does not raise `in_ready` until the next cycle.
- Boundary conditions:
  - Full FIFO with simultaneous write and pop: both occur, count is unchanged.
  - Full FIFO with write and no pop: data is dropped and `overflow` is set; it clears only on `rst`.
  - Empty FIFO: `out_valid`=0 and `out_data` holds its last value.
  - Pointers wrap modulo FIFO_DEPTH; `count` distinguishes full from empty.
  - `in_valid` while `in_ready`=0 is a protocol violation. The row is still tracked; overflow detection covers the consequence.
- Arithmetic: values are passed through unmodified (no width change) except for the optional feature below.

Optional Feature:
- Macro OUTPUT_RELU_EN.
- Defined: each column is clamped to 0 if negative (sign bit set) before the FIFO write; non-negative values pass unchanged. This is combinational on the write path and adds no latency.
- Undefined: signed values pass through unchanged.

Decomposition:
- Package `systolic_pkg`:
  - localparams DEFAULT_DATA_WIDTH=8, DEFAULT_ACC_WIDTH=32;
  - typedef `acc_t` (signed [ACC_WIDTH-1:0]);
  - function `relu(acc_t)`.
- Sub-module `sync_row_fifo`:
  - parameterized width/depth;
  - ports push/pop/full/empty/count/overflow.
- Deskew and credit logic stay in the top module.

Test Plan (N=2, PIPE_LATENCY=2, FIFO_DEPTH=4, `enable`=1 unless stated):
- Single row: `in_valid` at cycle 0; drive `c_in[0]`=5 at cycle 2 and `c_in[1]`=−7 at cycle 3 -> `out_valid`=1 at cycle 4 with `out_data`={5,−7}; pop with `out_ready`=1 -> `out_valid`=0 at cycle 5.
- Enable stall: as above but `enable`=0 during cycles 1–2 -> all arrivals shift by 2 cycles; `out_data`={5,−7} with `out_valid` at cycle 6; no duplicate row.
- Backpressure/credit: `out_ready`=0; inject rows back-to-back while `in_ready`=1 -> exactly 4 rows accepted; `in_ready`=0 after the 4th; `overflow`=0; drain returns rows in order 1..4.
- Overflow: force `in_valid` with `in_ready`=0 while the FIFO is full and `out_ready`=0 -> `overflow`=1 sticky, FIFO contents unchanged.
- Simultaneous push/pop at full with `out_ready`=1 -> count stays 4, order preserved, `overflow`=0.
- Reset mid-flight: assert `rst` one cycle after 2 rows are injected -> `out_valid`=0, `in_ready`=1 immediately; no output rows after reset release.
- With OUTPUT_RELU_EN: the row {5,−7} yields {5,0}.
